// File: rtl/bus_pkg.sv
// Shared bus definitions for the Wishbone master arbiter and its neighbours.
// Contents: arbiter state encoding, size-code constants, the data word returned on
// an error completion, and the system address map.
package bus_pkg;

    typedef enum logic {
        StIdle    = 1'b0,
        StWaitAck = 1'b1
    } arb_state_e;

    // Size codes carried on the *_sel lines
    localparam logic [2:0] SEL_B  = 3'b000;
    localparam logic [2:0] SEL_H  = 3'b001;
    localparam logic [2:0] SEL_W  = 3'b010;
    localparam logic [2:0] SEL_BU = 3'b100;
    localparam logic [2:0] SEL_HU = 3'b101;

    localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

    // Address map
    localparam logic [31:0] RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] RAM_SIZE = 32'h0001_0000;
    localparam logic [31:0] IO_BASE  = 32'hFFFF_FFF0;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-requester picker.
// Ports:
//   i_req[1:0]    - request lines (bit 0 = M0, bit 1 = M1)
//   i_last_grant  - index of the previous winner
//   i_rr_en       - 1: alternate on contention, 0: M0 always wins
//   o_grant       - index of the winner (0 when nobody requests)
module arb_rr2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  logic       i_rr_en,
    output logic       o_grant
);

    always_comb begin
        case (i_req)
            2'b10:   o_grant = 1'b1;
            // On contention M1 only wins when alternating and M0 went last
            2'b11:   o_grant = i_rr_en & ~i_last_grant;
            default: o_grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: merges the data port (M0) and instruction-fetch port (M1)
// onto one bus master interface, one transaction outstanding at a time, with a bounded
// wait that completes hung transactions with an error.
// Ports:
//   i_clk, i_reset_n                 - clock, asynchronous active-low reset
//   i_mX_stb/we/addr/data/sel        - master X request
//   o_mX_data/ack/err/stall          - master X response
//   o_wb_stb/we/addr/data/sel        - bus request
//   i_wb_data/ack/stall              - bus response
module wb_master_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic [2:0]  i_m0_sel,
    output logic [31:0] o_m0_data,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m0_stall,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic [2:0]  i_m1_sel,
    output logic [31:0] o_m1_data,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_m1_stall,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [2:0]  o_wb_sel,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The counter starts at 0 in the first WAIT_ACK cycle, so the last allowed
    // wait cycle is the one where it reads TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic [2:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;

    logic w_grant;
    logic w_idle;
    logic w_wait;
    logic w_gnt_stb;
    logic w_accept;
    logic w_timeout;
    logic w_done_ok;
    logic w_done_err;
    logic w_tgt;

    arb_rr2 u_arb (
        .i_req        ({i_m1_stb, i_m0_stb}),
        .i_last_grant (r_last_grant),
        .i_rr_en      (ROUND_ROBIN != 0),
        .o_grant      (w_grant)
    );

    // Gating with i_reset_n makes outputs take reset values without a clock edge
    assign w_idle     = i_reset_n & (r_state == StIdle);
    assign w_wait     = i_reset_n & (r_state == StWaitAck);
    assign w_gnt_stb  = w_grant ? i_m1_stb : i_m0_stb;
    assign w_accept   = w_idle & w_gnt_stb & ~i_wb_stall;
    // Ack takes priority over a coinciding timeout
    assign w_timeout  = w_wait & ~i_wb_ack & (r_cnt == CNT_LAST);
    assign w_done_ok  = (w_accept | w_wait) & i_wb_ack;
    assign w_done_err = w_timeout;
    assign w_tgt      = w_idle ? w_grant : r_owner;

    always_comb begin
        o_wb_stb = w_idle & w_gnt_stb;
        if (w_idle) begin
            o_wb_we   = w_grant ? i_m1_we   : i_m0_we;
            o_wb_addr = w_grant ? i_m1_addr : i_m0_addr;
            o_wb_data = w_grant ? i_m1_data : i_m0_data;
            o_wb_sel  = w_grant ? i_m1_sel  : i_m0_sel;
        end else begin
            o_wb_we   = r_we;
            o_wb_addr = r_addr;
            o_wb_data = r_data;
            o_wb_sel  = r_sel;
        end
    end

    always_comb begin
        o_m0_ack   = (w_done_ok | w_done_err) & ~w_tgt;
        o_m1_ack   = (w_done_ok | w_done_err) & w_tgt;
        o_m0_err   = w_done_err & ~w_tgt;
        o_m1_err   = w_done_err & w_tgt;
        o_m0_data  = 32'h0;
        o_m1_data  = 32'h0;
        if (o_m0_ack) o_m0_data = w_done_err ? BUS_ERR_DATA : i_wb_data;
        if (o_m1_ack) o_m1_data = w_done_err ? BUS_ERR_DATA : i_wb_data;
        o_m0_stall = (w_idle & ~w_grant) ? i_wb_stall : 1'b1;
        o_m1_stall = (w_idle & w_grant)  ? i_wb_stall : 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= 32'h0;
            r_data       <= 32'h0;
            r_sel        <= 3'b000;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_we         <= o_wb_we;
                        r_addr       <= o_wb_addr;
                        r_data       <= o_wb_data;
                        r_sel        <= o_wb_sel;
                        r_cnt        <= '0;
                        if (!i_wb_ack) r_state <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (i_wb_ack || w_timeout) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
